// File: rtl/line_buffer_if.sv
// Pixel-stream bundle between a pixel source and line_buffer_ctrl.
// master : pixel source, drives data_en/data_in/sof, observes the sequencer outputs.
// slave  : line_buffer_ctrl, consumes the stream and drives the chain/window controls.
//   data_en, data_in[7:0], sof         : source -> sequencer
//   line_shift_en, pixel_out[7:0], col, row, win_valid, frame_done, frame_err, busy : sequencer -> consumers
interface line_buffer_if #(
  parameter int COL_W = 11,
  parameter int ROW_W = 10
);
  logic             data_en;
  logic [7:0]       data_in;
  logic             sof;
  logic             line_shift_en;
  logic [7:0]       pixel_out;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             win_valid;
  logic             frame_done;
  logic             frame_err;
  logic             busy;

  modport master (
    output data_en, data_in, sof,
    input  line_shift_en, pixel_out, col, row, win_valid, frame_done, frame_err, busy
  );

  modport slave (
    input  data_en, data_in, sof,
    output line_shift_en, pixel_out, col, row, win_valid, frame_done, frame_err, busy
  );
endinterface

// File: rtl/line_buffer_ctrl.sv
// Sequencer for the KERNEL-1 memory_line row buffers feeding a sliding-window
// convolution. Tracks column/row of the incoming pixel stream, drives the shared
// shift enable and registered pixel into the chain, flags complete windows, and
// reports frame completion and mid-frame start-of-frame errors.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   lb  : line_buffer_if slave (stream in, chain/window controls out), 1-cycle latency
module line_buffer_ctrl #(
  parameter int IMG_W  = 1280,
  parameter int IMG_H  = 720,
  parameter int KERNEL = 3,
  parameter int COL_W  = 11,
  parameter int ROW_W  = 10
) (
  input  logic           clk,
  input  logic           rst,
  line_buffer_if.slave   lb
);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] WIN_COL   = COL_W'(KERNEL - 1);
  localparam logic [ROW_W-1:0] FILL_LAST = ROW_W'(KERNEL - 2);

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d, cur_col;
  logic [ROW_W-1:0] row_q, row_d, cur_row;
  logic             shift_q, shift_d;
  logic [7:0]       pix_q, pix_d;
  logic [COL_W-1:0] ocol_q, ocol_d;
  logic [ROW_W-1:0] orow_q, orow_d;
  logic             win_q, win_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             restart;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    shift_d = 1'b0;
    pix_d   = pix_q;
    ocol_d  = ocol_q;
    orow_d  = orow_q;
    win_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cur_col = col_q;
    cur_row = row_q;
    restart = 1'b0;

    if (state_q == DONE) begin
      // One dead cycle after the last pixel; anything arriving now is dropped.
      state_d = IDLE;
    end else if (lb.data_en) begin
      shift_d = 1'b1;
      pix_d   = lb.data_in;
      if (state_q == IDLE) begin
        cur_col = '0;
        cur_row = '0;
      end else if (lb.sof && (col_q != '0 || row_q != '0)) begin
        // Resync: this pixel becomes the new origin and takes priority over end-of-frame.
        cur_col = '0;
        cur_row = '0;
        err_d   = 1'b1;
        restart = 1'b1;
      end
      ocol_d = cur_col;
      orow_d = cur_row;

      if (state_q == RUN && !restart) begin
        win_d   = (cur_col >= WIN_COL);
        state_d = RUN;
        if (cur_col == COL_LAST && cur_row == ROW_LAST) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end else begin
        // IDLE and restarts behave as FILL for this pixel.
        state_d = FILL;
        if (cur_col == COL_LAST && cur_row == FILL_LAST) state_d = RUN;
      end

      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
        row_d = cur_row;
      end
    end

    busy_d = (state_d == FILL) || (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      shift_q <= 1'b0;
      pix_q   <= '0;
      ocol_q  <= '0;
      orow_q  <= '0;
      win_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      shift_q <= shift_d;
      pix_q   <= pix_d;
      ocol_q  <= ocol_d;
      orow_q  <= orow_d;
      win_q   <= win_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign lb.line_shift_en = shift_q;
  assign lb.pixel_out     = pix_q;
  assign lb.col           = ocol_q;
  assign lb.row           = orow_q;
  assign lb.win_valid     = win_q;
  assign lb.frame_done    = done_q;
  assign lb.frame_err     = err_q;
  assign lb.busy          = busy_q;

endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
Sequencer for the chain of KERNEL-1 memory_line row buffers that feeds the sliding-window convolution stage. It accepts the raw 8-bit pixel stream with a data_en strobe and tracks column and row position. It drives the shared shift enable and the registered pixel into the memory_line chain. It flags which cycles carry a complete KERNEL x KERNEL window, and marks frame completion and frame resync errors.

Parameters:
IMG_W, 1280, pixels per line; must equal the memory_line depth.
IMG_H, 720, lines per frame.
KERNEL, 3, window size; the chain holds KERNEL-1 memory_lines; legal range 2..8.
COL_W, 11, column counter width; must satisfy 2^COL_W >= IMG_W.
ROW_W, 10, row counter width; must satisfy 2^ROW_W >= IMG_H.

Ports:
clk  in  1  system clock, all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
data_en  in  1  input pixel valid strobe; may gap arbitrarily.
data_in  in  8  input pixel, sampled when data_en=1.
sof  in  1  start-of-frame marker, qualified by data_en.
line_shift_en  out  1  shift enable to every memory_line data_en in the chain.
pixel_out  out  8  registered pixel to the head of the chain and to window tap 0.
col  out  COL_W  column index of the pixel currently on pixel_out.
row  out  ROW_W  row index of the pixel currently on pixel_out.
win_valid  out  1  the current pixel_out cycle completes a full window.
frame_done  out  1  one-cycle pulse on the cycle carrying the last pixel of a frame.
frame_err  out  1  one-cycle pulse when sof arrives mid-frame.
busy  out  1  high in FILL or RUN.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; internal col/row counters cleared to 0. All outputs are 0: line_shift_en, pixel_out, col, row, win_valid, frame_done, frame_err, busy.
- Reset mid-frame: all of the above apply immediately, and the partial frame is discarded. The memory_line contents are not cleared; they are overwritten by the next FILL.
- Accept rule: a pixel is accepted on every edge where data_en=1 and state is not DONE. There is no backpressure; DONE lasts exactly one cycle.
- Latency: exactly 1 cycle. line_shift_en, pixel_out, col, row, win_valid, frame_done and frame_err all refer to the pixel accepted on the previous edge. The outputs are registered and mutually aligned.
- Inactive cycles: when data_en=0, line_shift_en=0, win_valid=0, frame_done=0 and frame_err=0. pixel_out, col and row hold their last values.
- Counters:
  - col increments on each accepted pixel and wraps from IMG_W-1 to 0.
  - On that wrap, row increments.
  - No arithmetic saturates; the counters never exceed IMG_W-1 / IMG_H-1.
- State IDLE:
  - Accepted pixel (sof ignored) -> takes position col=0,row=0.
  - Next state is FILL, or RUN when KERNEL-1=0 (not legal, so always FILL).
- State FILL (rows 0..KERNEL-2): win_valid=0 for every pixel. Next state is RUN when the accepted pixel is at col=IMG_W-1 and row=KERNEL-2.
- State RUN (rows KERNEL-1..IMG_H-1): win_valid=1 for accepted pixels with col >= KERNEL-1.
- End of frame: the accepted pixel at col=IMG_W-1,row=IMG_H-1 raises frame_done (with win_valid=1) on the output cycle and moves the state to DONE.
- State DONE: busy=0; data_en is ignored for this one cycle; next state is IDLE.
- Window count per frame: (IMG_H-KERNEL+1)*(IMG_W-KERNEL+1) win_valid cycles.
- sof handling:
  - sof=1 with data_en=1 in FILL or RUN, when the pixel is not at position col=0,row=0: frame_err pulses.
  - That pixel is treated as col=0,row=0 and the state is forced to FILL.
  - sof=1 in IDLE, or exactly at position 0,0, is legal and gives no error.
  - sof without data_en is ignored.
- Simultaneous sof and end-of-frame position: sof wins. frame_err=1, frame_done=0, and the state goes to FILL.
- busy=1 exactly while state is FILL or RUN; it is registered and aligned with the outputs.

Test Plan:
1. IMG_W=8, IMG_H=4, KERNEL=3. Hold rst 2 cycles, then stream 32 pixels with continuous data_en -> 12 win_valid pulses at (row,col) in {2,3}x{2..7}; frame_done once with row=3,col=7; busy low 1 cycle after.
2. Same params, random 0–3 cycle gaps in data_en over 32 pixels -> identical win_valid/col/row sequence compressed over valid cycles. line_shift_en count = 32; no outputs change while gaps hold.
3. Assert sof with data_en at pixel 13 (row1,col5) -> frame_err pulse; that pixel reports row=0,col=0 and the state restarts FILL. Then 32 more pixels -> 12 windows and frame_done.
4. Assert rst at pixel 20 mid-RUN -> next cycle all outputs 0 and state IDLE. The next 32 pixels produce a clean frame with 12 windows.
5. Two back-to-back frames with data_en held high for 65 cycles -> the pixel arriving during DONE is dropped. Frame 2 starts on the following pixel and line_shift_en totals 64.
6. Defaults (1280x720, K=3), continuous stream -> exactly 917604 win_valid cycles; frame_done on cycle 921600 after first accept (+1 latency).
